// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: opcodes, functs,
// FSM state encoding, control-bus encodings and the instruction classes.
package mips_ctrl_pkg;

  // Opcode field values
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Funct field values (Op = 0)
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  // ALUSrc
  localparam logic [2:0] SRC_RD2   = 3'd0;
  localparam logic [2:0] SRC_IMM   = 3'd1;
  // ExtOp
  localparam logic [2:0] EXT_ZERO  = 3'd0;
  localparam logic [2:0] EXT_SIGN  = 3'd1;
  localparam logic [2:0] EXT_HI    = 3'd2;
  // ALUControl
  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_OR    = 3'd2;
  // nPCSel
  localparam logic [2:0] NPC_PC4   = 3'd0;
  localparam logic [2:0] NPC_BEQ   = 3'd1;
  localparam logic [2:0] NPC_JUMP  = 3'd2;
  localparam logic [2:0] NPC_JR    = 3'd3;
  // RegDst
  localparam logic [2:0] DST_RT    = 3'd0;
  localparam logic [2:0] DST_RD    = 3'd1;
  localparam logic [2:0] DST_RA    = 3'd2;
  // RegWriteSel
  localparam logic [2:0] WSEL_ALU  = 3'd0;
  localparam logic [2:0] WSEL_MEM  = 3'd1;
  localparam logic [2:0] WSEL_PC4  = 3'd2;
  // DataExtOp
  localparam logic [2:0] DEXT_WORD = 3'd0;

  typedef enum logic [3:0] {
    RTYPE_ALU = 4'd0,
    ORI       = 4'd1,
    LUI       = 4'd2,
    LW        = 4'd3,
    SW        = 4'd4,
    BEQ       = 4'd5,
    J         = 4'd6,
    JAL       = 4'd7,
    JR        = 4'd8,
    NOP       = 4'd9
  } instr_class_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: instruction fields and Zero in, control
// buses, debug state, retire pulse and retire counter out.
interface multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       Op;
  logic [5:0]       Func;
  logic             Zero;
  logic             PCWrite;
  logic             IRWrite;
  logic [2:0]       ALUSrc;
  logic [2:0]       ExtOp;
  logic [2:0]       ALUControl;
  logic [2:0]       RegWrite;
  logic [2:0]       MemWrite;
  logic [2:0]       RegDst;
  logic [2:0]       nPCSel;
  logic [2:0]       RegWriteSel;
  logic [2:0]       DataExtOp;
  logic [2:0]       state;
  logic             instr_done;
  logic [CNT_W-1:0] retired;

  // Controller side
  modport master (
    input  Op, Func, Zero,
    output PCWrite, IRWrite, ALUSrc, ExtOp, ALUControl, RegWrite, MemWrite,
           RegDst, nPCSel, RegWriteSel, DataExtOp, state, instr_done, retired
  );

  // Datapath side
  modport slave (
    output Op, Func, Zero,
    input  PCWrite, IRWrite, ALUSrc, ExtOp, ALUControl, RegWrite, MemWrite,
           RegDst, nPCSel, RegWriteSel, DataExtOp, state, instr_done, retired
  );
endinterface

// File: rtl/multicycle_ctrl_instr_decode.sv
// Combinational decode of the latched Op/Func into an instruction class and
// the ALU function that class needs (addu vs subu share one class).
module instr_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0]   op,
  input  logic [5:0]   func,
  output instr_class_t iclass,
  output logic [2:0]   alu_fn
);

  // Class and ALU function lookup; anything unrecognised becomes NOP
  always_comb begin
    iclass = NOP;
    alu_fn = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        case (func)
          FN_ADDU: begin iclass = RTYPE_ALU; alu_fn = ALU_ADD; end
          FN_SUBU: begin iclass = RTYPE_ALU; alu_fn = ALU_SUB; end
          FN_JR:   iclass = JR;
          default: iclass = NOP;
        endcase
      end
      OP_ORI:  begin iclass = ORI; alu_fn = ALU_OR;  end
      OP_LUI:  begin iclass = LUI; alu_fn = ALU_OR;  end
      OP_LW:   begin iclass = LW;  alu_fn = ALU_ADD; end
      OP_SW:   begin iclass = SW;  alu_fn = ALU_ADD; end
      OP_BEQ:  begin iclass = BEQ; alu_fn = ALU_SUB; end
      OP_J:    iclass = J;
      OP_JAL:  iclass = JAL;
      default: iclass = NOP;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM (Moore): FETCH/DECODE/EXEC/MEM/WB sequencing,
// control bus generation from the latched instruction class, retire counter.
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
)(
  input  logic             clk,
  input  logic             reset,
  multicycle_ctrl_if.master bus
);

  state_t           state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic [5:0]       func_q, func_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  instr_class_t     iclass;
  logic [2:0]       alu_fn;

  logic             pc_write, ir_write, done;
  logic [2:0]       alu_src, ext_op, alu_ctrl, reg_write, mem_write;
  logic [2:0]       reg_dst, npc_sel, wsel;

  instr_decode u_decode (
    .op     (op_q),
    .func   (func_q),
    .iclass (iclass),
    .alu_fn (alu_fn)
  );

  // State, instruction latch and retire counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      func_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      func_q    <= func_d;
      retired_q <= retired_d;
    end
  end

  // Next state and Moore outputs from state and latched instruction class
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    func_d    = func_q;
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    done      = 1'b0;
    alu_src   = SRC_RD2;
    ext_op    = EXT_ZERO;
    alu_ctrl  = ALU_ADD;
    reg_write = 3'd0;
    mem_write = 3'd0;
    reg_dst   = DST_RT;
    npc_sel   = NPC_PC4;
    wsel      = WSEL_ALU;

    // ALU operand controls are held from EXEC onward so the datapath
    // result stays stable through MEM and WB.
    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      case (iclass)
        RTYPE_ALU, BEQ: alu_ctrl = alu_fn;
        ORI:     begin alu_src = SRC_IMM; ext_op = EXT_ZERO; alu_ctrl = alu_fn; end
        LUI:     begin alu_src = SRC_IMM; ext_op = EXT_HI;   alu_ctrl = alu_fn; end
        LW, SW:  begin alu_src = SRC_IMM; ext_op = EXT_SIGN; alu_ctrl = alu_fn; end
        default: ;
      endcase
    end

    case (state_q)
      S_FETCH: begin
        ir_write = 1'b1;
        op_d     = bus.Op;
        func_d   = bus.Func;
        state_d  = S_DECODE;
      end
      S_DECODE: begin
        case (iclass)
          J:   begin pc_write = 1'b1; npc_sel = NPC_JUMP; done = 1'b1; state_d = S_FETCH; end
          JR:  begin pc_write = 1'b1; npc_sel = NPC_JR;   done = 1'b1; state_d = S_FETCH; end
          JAL: state_d = S_WB;
          RTYPE_ALU, ORI, LUI, LW, SW, BEQ: state_d = S_EXEC;
          default: begin pc_write = 1'b1; npc_sel = NPC_PC4; done = 1'b1; state_d = S_FETCH; end
        endcase
      end
      S_EXEC: begin
        case (iclass)
          // NPC picks taken/not-taken from Zero itself
          BEQ:     begin pc_write = 1'b1; npc_sel = NPC_BEQ; done = 1'b1; state_d = S_FETCH; end
          LW, SW:  state_d = S_MEM;
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        case (iclass)
          SW:      begin mem_write = 3'd1; pc_write = 1'b1; npc_sel = NPC_PC4; done = 1'b1; state_d = S_FETCH; end
          LW:      state_d = S_WB;
          default: state_d = S_FETCH;
        endcase
      end
      S_WB: begin
        reg_write = 3'd1;
        pc_write  = 1'b1;
        done      = 1'b1;
        state_d   = S_FETCH;
        case (iclass)
          RTYPE_ALU: begin reg_dst = DST_RD; wsel = WSEL_ALU; end
          ORI, LUI:  reg_dst = DST_RT;
          LW:        begin reg_dst = DST_RT; wsel = WSEL_MEM; end
          JAL:       begin reg_dst = DST_RA; wsel = WSEL_PC4; npc_sel = NPC_JUMP; end
          default:   ;
        endcase
      end
      default: state_d = S_FETCH;
    endcase

    retired_d = retired_q + CNT_W'(done);
  end

  // While reset is high every output reads as zero and state as FETCH
  assign bus.PCWrite     = reset ? 1'b0 : pc_write;
  assign bus.IRWrite     = reset ? 1'b0 : ir_write;
  assign bus.ALUSrc      = reset ? 3'd0 : alu_src;
  assign bus.ExtOp       = reset ? 3'd0 : ext_op;
  assign bus.ALUControl  = reset ? 3'd0 : alu_ctrl;
  assign bus.RegWrite    = reset ? 3'd0 : reg_write;
  assign bus.MemWrite    = reset ? 3'd0 : mem_write;
  assign bus.RegDst      = reset ? 3'd0 : reg_dst;
  assign bus.nPCSel      = reset ? 3'd0 : npc_sel;
  assign bus.RegWriteSel = reset ? 3'd0 : wsel;
  assign bus.DataExtOp   = DEXT_WORD;
  assign bus.state       = reset ? S_FETCH : state_q;
  assign bus.instr_done  = reset ? 1'b0 : done;
  assign bus.retired     = reset ? '0 : retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Table-driven bench for multicycle_ctrl: one row per clock cycle with the
// inputs for that cycle and the expected Moore outputs, plus hand sequences
// for reset during WB and retire-counter wrap on a narrow-counter instance.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic reset2 = 1'b1;
  always #5 clk = ~clk;

  multicycle_ctrl_if #(.CNT_W(32)) bus ();
  multicycle_ctrl #(.CNT_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  multicycle_ctrl_if #(.CNT_W(2)) bus2 ();
  multicycle_ctrl #(.CNT_W(2)) dut2 (.clk(clk), .reset(reset2), .bus(bus2));

  typedef struct packed {
    logic [2:0]  st;
    logic        pcw;
    logic        irw;
    logic [2:0]  asrc;
    logic [2:0]  ext;
    logic [2:0]  aluc;
    logic [2:0]  rw;
    logic [2:0]  mw;
    logic [2:0]  rdst;
    logic [2:0]  nps;
    logic [2:0]  rws;
    logic [2:0]  dext;
    logic        done;
    logic [31:0] ret;
  } outs_t;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic [5:0] func;
    logic       zero;
    outs_t      exp;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic outs_t o(int st, int pcw, int irw, int asrc, int ext, int aluc,
                              int rw, int mw, int rdst, int nps, int rws, int done, int ret);
    outs_t r;
    r.st = 3'(st);   r.pcw = 1'(pcw);  r.irw = 1'(irw);
    r.asrc = 3'(asrc); r.ext = 3'(ext); r.aluc = 3'(aluc);
    r.rw = 3'(rw);   r.mw = 3'(mw);    r.rdst = 3'(rdst);
    r.nps = 3'(nps); r.rws = 3'(rws);  r.dext = 3'd0;
    r.done = 1'(done); r.ret = 32'(ret);
    return r;
  endfunction

  task automatic add(input int rst, input int op, input int func, input int zero, input outs_t e);
    vec_t v;
    v.rst = 1'(rst); v.op = 6'(op); v.func = 6'(func); v.zero = 1'(zero); v.exp = e;
    vecs.push_back(v);
  endtask

  function automatic outs_t sample();
    outs_t r;
    r.st = bus.state; r.pcw = bus.PCWrite; r.irw = bus.IRWrite;
    r.asrc = bus.ALUSrc; r.ext = bus.ExtOp; r.aluc = bus.ALUControl;
    r.rw = bus.RegWrite; r.mw = bus.MemWrite; r.rdst = bus.RegDst;
    r.nps = bus.nPCSel; r.rws = bus.RegWriteSel; r.dext = bus.DataExtOp;
    r.done = bus.instr_done; r.ret = bus.retired;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end else
      $display("ok   %s: %0h", name, got);
  endtask

  initial begin
    outs_t got;
    bus.Op = '0; bus.Func = '0; bus.Zero = 1'b0;
    bus2.Op = 6'h3F; bus2.Func = 6'h3F; bus2.Zero = 1'b0;

    //     rst op    func  z  st pcw irw src ext alu rw mw dst nps wsel done ret
    add(1, 0,    0,    0, o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(1, 0,    0,    0, o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // addu; Op/Func scrambled after FETCH must not matter
    add(0, 0,    'h21, 0, o(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(0, 'h3F, 'h3F, 0, o(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(0, 'h3F, 'h3F, 1, o(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(0, 'h3F, 'h3F, 0, o(4, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0));
    // lw
    add(0, 'h23, 0,    0, o(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    add(0, 'h23, 0,    0, o(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    add(0, 'h23, 0,    0, o(2, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1));
    add(0, 'h23, 0,    0, o(3, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1));
    add(0, 'h23, 0,    0, o(4, 1, 0, 1, 1, 0, 1, 0, 0, 0, 1, 1, 1));
    // sw
    add(0, 'h2B, 0,    0, o(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    add(0, 'h2B, 0,    0, o(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    add(0, 'h2B, 0,    0, o(2, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 2));
    add(0, 'h2B, 0,    0, o(3, 1, 0, 1, 1, 0, 0, 1, 0, 0, 0, 1, 2));
    // beq, Zero=1
    add(0, 'h04, 0,    1, o(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3));
    add(0, 'h04, 0,    1, o(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3));
    add(0, 'h04, 0,    1, o(2, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1, 3));
    // beq, Zero=0
    add(0, 'h04, 0,    0, o(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4));
    add(0, 'h04, 0,    0, o(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4));
    add(0, 'h04, 0,    0, o(2, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1, 4));
    // jal
    add(0, 'h03, 0,    0, o(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5));
    add(0, 'h03, 0,    0, o(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5));
    add(0, 'h03, 0,    0, o(4, 1, 0, 0, 0, 0, 1, 0, 2, 2, 2, 1, 5));
    // jr
    add(0, 0,    'h08, 0, o(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6));
    add(0, 0,    'h08, 0, o(1, 1, 0, 0, 0, 0, 0, 0, 0, 3, 0, 1, 6));
    // unknown opcode 3Fh -> NOP
    add(0, 'h3F, 0,    0, o(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7));
    add(0, 'h3F, 0,    0, o(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7));
    // ori interrupted by reset in EXEC
    add(0, 'h0D, 0,    0, o(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8));
    add(0, 'h0D, 0,    0, o(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8));
    add(1, 'h0D, 0,    0, o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // full ori after reset
    add(0, 'h0D, 0,    0, o(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(0, 'h0D, 0,    0, o(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(0, 'h0D, 0,    0, o(2, 0, 0, 1, 0, 2, 0, 0, 0, 0, 0, 0, 0));
    add(0, 'h0D, 0,    0, o(4, 1, 0, 1, 0, 2, 1, 0, 0, 0, 0, 1, 0));
    // lui
    add(0, 'h0F, 0,    0, o(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    add(0, 'h0F, 0,    0, o(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    add(0, 'h0F, 0,    0, o(2, 0, 0, 1, 2, 2, 0, 0, 0, 0, 0, 0, 1));
    add(0, 'h0F, 0,    0, o(4, 1, 0, 1, 2, 2, 1, 0, 0, 0, 0, 1, 1));
    // j
    add(0, 'h02, 0,    0, o(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    add(0, 'h02, 0,    0, o(1, 1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 1, 2));
    // subu
    add(0, 0,    'h23, 0, o(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3));
    add(0, 0,    'h23, 0, o(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3));
    add(0, 0,    'h23, 0, o(2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3));
    add(0, 0,    'h23, 0, o(4, 1, 0, 0, 0, 1, 1, 0, 1, 0, 0, 1, 3));
    // addu fetched here, continued by the hand sequence below
    add(0, 0,    'h21, 0, o(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4));

    foreach (vecs[i]) begin
      @(negedge clk);
      reset    = vecs[i].rst;
      bus.Op   = vecs[i].op;
      bus.Func = vecs[i].func;
      bus.Zero = vecs[i].zero;
      #1;
      got = sample();
      n_cmp++;
      if (got !== vecs[i].exp) begin
        n_fail++;
        $display("FAIL row %0d: got %h expected %h", i, got, vecs[i].exp);
      end else
        $display("ok   row %0d: op=%h func=%h rst=%0d -> %h", i, vecs[i].op, vecs[i].func, vecs[i].rst, got);
    end

    // Reset asserted during the WB cycle of addu: no strobes, back to FETCH
    @(negedge clk); #1;
    chk("addu_decode_state", 64'(bus.state), 64'd1);
    @(negedge clk); #1;
    chk("addu_exec_state", 64'(bus.state), 64'd2);
    @(negedge clk); #1;
    chk("addu_wb_regwrite", 64'(bus.RegWrite), 64'd1);
    reset = 1'b1; #1;
    chk("rst_wb_regwrite", 64'(bus.RegWrite), 64'd0);
    chk("rst_wb_pcwrite", 64'(bus.PCWrite), 64'd0);
    chk("rst_wb_state", 64'(bus.state), 64'd0);
    chk("rst_wb_done", 64'(bus.instr_done), 64'd0);
    @(negedge clk);
    reset = 1'b0; #1;
    chk("post_rst_state", 64'(bus.state), 64'd0);
    chk("post_rst_irwrite", 64'(bus.IRWrite), 64'd1);
    chk("post_rst_retired", 64'(bus.retired), 64'd0);

    // Retire counter wrap on a 2-bit instance running back-to-back NOPs
    @(negedge clk);
    reset2 = 1'b0;
    repeat (6) @(negedge clk);
    #1 chk("wrap_after_3", 64'(bus2.retired), 64'd3);
    repeat (2) @(negedge clk);
    #1 chk("wrap_after_4", 64'(bus2.retired), 64'd0);
    repeat (2) @(negedge clk);
    #1 chk("wrap_after_5", 64'(bus2.retired), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
